// File: rtl/pio_edge_irq_ext.sv
// Avalon-MM input PIO: synchronised, glitch-filtered inputs with per-bit
// rise/fall edge capture, a masked level interrupt and a saturating event counter.
module pio_edge_irq_ext #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_BITS = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] in_port
);

   typedef enum logic [2:0] {
      A_DATA       = 3'd0,
      A_RISE_EN    = 3'd1,
      A_IRQ_MASK   = 3'd2,
      A_EDGE_CAP   = 3'd3,
      A_FALL_EN    = 3'd4,
      A_FILTER_LEN = 3'd5,
      A_EVENT_CNT  = 3'd6
   } reg_addr_e;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0][FILTER_BITS-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]                  f_q, f_d;
   logic [WIDTH-1:0]                  fd_q, fd_d;
   logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
   logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0]                  edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
   logic [FILTER_BITS-1:0]            filter_len_q, filter_len_d;
   logic [15:0]                       event_cnt_q, event_cnt_d;
   logic [31:0]                       readdata_q, readdata_d;

   logic             wr;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] w1c;
   logic             unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign s            = sync_q[SYNC_STAGES-1];
   assign ev           = (f_q & ~fd_q & rise_en_q) | (~f_q & fd_q & fall_en_q);
   assign w1c          = (wr && address == A_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
   assign irq          = |(edge_cap_q & irq_mask_q);
   assign readdata     = readdata_q;
   assign unused_wdata = ^writedata;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      sync_d       = sync_q;
      cnt_d        = cnt_q;
      f_d          = f_q;
      rise_en_d    = rise_en_q;
      irq_mask_d   = irq_mask_q;
      fall_en_d    = fall_en_q;
      filter_len_d = filter_len_q;
      event_cnt_d  = event_cnt_q;
      readdata_d   = '0;

      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

      // >= rather than == lets an in-flight count finish when the length shrinks
      for (int i = 0; i < WIDTH; i++) begin
         if (s[i] == f_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= filter_len_q) begin
            f_d[i]   = s[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + FILTER_BITS'(1);
         end
      end

      fd_d       = f_q;
      edge_cap_d = (edge_cap_q | ev) & ~w1c;

      if (wr && address == A_EVENT_CNT) begin
         event_cnt_d = '0;
      end else if (|ev && event_cnt_q != 16'hFFFF) begin
         event_cnt_d = event_cnt_q + 16'd1;
      end

      if (wr) begin
         case (address)
            A_RISE_EN:    rise_en_d    = writedata[WIDTH-1:0];
            A_IRQ_MASK:   irq_mask_d   = writedata[WIDTH-1:0];
            A_FALL_EN:    fall_en_d    = writedata[WIDTH-1:0];
            A_FILTER_LEN: filter_len_d = writedata[FILTER_BITS-1:0];
            default: ;
         endcase
      end

      case (address)
         A_DATA:       readdata_d[WIDTH-1:0]       = f_q;
         A_RISE_EN:    readdata_d[WIDTH-1:0]       = rise_en_q;
         A_IRQ_MASK:   readdata_d[WIDTH-1:0]       = irq_mask_q;
         A_EDGE_CAP:   readdata_d[WIDTH-1:0]       = edge_cap_q;
         A_FALL_EN:    readdata_d[WIDTH-1:0]       = fall_en_q;
         A_FILTER_LEN: readdata_d[FILTER_BITS-1:0] = filter_len_q;
         A_EVENT_CNT:  readdata_d[15:0]            = event_cnt_q;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q       <= '0;
         cnt_q        <= '0;
         f_q          <= '0;
         fd_q         <= '0;
         rise_en_q    <= '1;
         irq_mask_q   <= '0;
         edge_cap_q   <= '0;
         fall_en_q    <= '0;
         filter_len_q <= '0;
         event_cnt_q  <= '0;
         readdata_q   <= '0;
      end else begin
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         f_q          <= f_d;
         fd_q         <= fd_d;
         rise_en_q    <= rise_en_d;
         irq_mask_q   <= irq_mask_d;
         edge_cap_q   <= edge_cap_d;
         fall_en_q    <= fall_en_d;
         filter_len_q <= filter_len_d;
         event_cnt_q  <= event_cnt_d;
         readdata_q   <= readdata_d;
      end
   end

endmodule
